// File: rtl/core_pkg.sv
// Shared core types and constants used by fetch and decode.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INS_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush; flush beats push and pop.
module fetch_queue
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  fetch_entry_t                wdata_i,
  output fetch_entry_t                rdata_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
      if (pop_i)  rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
      unique case ({push_i, pop_i})
        2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
        2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty entries are never presented downstream.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC, reads the ROM and queues {pc, ins} for decode.
module inst_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_ins,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_ins,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             push_c;
  logic             pop_c;
  fetch_entry_t     wr_entry;
  fetch_entry_t     rd_entry;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;

  assign out_valid = (q_count != '0);
  assign pop_c     = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign push_c    = !redirect && (!q_full || pop_c);
  assign wr_entry  = '{pc: pc_q, ins: rom_ins};

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end else if (push_c) begin
      pc_d = XLEN'(pc_q + XLEN'(4));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC & ALIGN_MASK;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .flush_i (redirect),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // pc_q is always word aligned, so it drives the ROM directly.
  assign rom_addr = pc_q;
  assign out_ins  = q_empty ? INS_NOP : rd_entry.ins;
  assign out_pc   = q_empty ? '0      : rd_entry.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized run against a queue model.
module tb_inst_fetch;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic [31:0] rom_addr, rom_ins;
  logic        out_valid;
  logic [31:0] out_ins, out_pc;

  logic        rst_w;
  logic        redirect_w;
  logic [31:0] redirect_pc_w;
  logic        out_ready_w;
  logic [31:0] rom_addr_w, rom_ins_w;
  logic        out_valid_w;
  logic [31:0] out_ins_w, out_pc_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: a plain queue of entries and the next fetch address.
  fetch_entry_t mq[$];
  logic [31:0]  mpc;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    case (addr[4:2])
      3'd0: rom_word = 32'h0400_2083;
      3'd1: rom_word = 32'h0000_8133;
      3'd2: rom_word = 32'h0000_01b3;
      3'd3: rom_word = 32'h0021_81b3;
      3'd4: rom_word = 32'hfff1_0113;
      3'd5: rom_word = 32'hfe01_1ce3;
      3'd6: rom_word = 32'h0830_2023;
      default: rom_word = 32'h0000_006f;
    endcase
  endfunction

  assign rom_ins   = rom_word(rom_addr);
  assign rom_ins_w = rom_word(rom_addr_w);

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_ins     (rom_ins),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ins     (out_ins),
    .out_pc      (out_pc)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk         (clk),
    .rst         (rst_w),
    .rom_addr    (rom_addr_w),
    .rom_ins     (rom_ins_w),
    .redirect    (redirect_w),
    .redirect_pc (redirect_pc_w),
    .out_valid   (out_valid_w),
    .out_ready   (out_ready_w),
    .out_ins     (out_ins_w),
    .out_pc      (out_pc_w)
  );

  // Advance one clock, stepping the model with the inputs applied this cycle.
  task automatic tick();
    logic pop, push;
    if (rst) begin
      mq.delete();
      mpc = 32'h0;
    end else begin
      pop  = (mq.size() != 0) && out_ready;
      push = !redirect && ((mq.size() < 2) || pop);
      if (redirect) begin
        mq.delete();
        mpc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back('{pc: mpc, ins: rom_word(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    tick(); tick();
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %h want 0", out_valid); end
    if (out_ins !== 32'h13) begin n_fail++; $display("FAIL reset_ins got %h want 00000013", out_ins); end
    if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", out_pc); end
    if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL reset_rom_addr got %h want 0", rom_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_ins [7];
    exp_ins = '{32'h04002083, 32'h00008133, 32'h000001b3, 32'h002181b3,
                32'hfff10113, 32'hfe011ce3, 32'h08302023};
    rst = 1'b0; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      n_checks += 3;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %h want 1", k, out_valid); end
      if (out_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc[%0d] got %h want %h", k, out_pc, 32'(4 * k)); end
      if (out_ins !== exp_ins[k]) begin n_fail++; $display("FAIL stream_ins[%0d] got %h want %h", k, out_ins, exp_ins[k]); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    do_reset();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks += 2;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %h want 1", i, out_valid); end
      if (out_pc !== 32'h0) begin n_fail++; $display("FAIL bp_pc[%0d] got %h want 0", i, out_pc); end
      if (i >= 1) begin
        n_checks++;
        if (rom_addr !== 32'h8) begin n_fail++; $display("FAIL bp_rom_addr[%0d] got %h want 8", i, rom_addr); end
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks += 2;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid[%0d] got %h want 1", k, out_valid); end
      if (out_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL bp_release_pc[%0d] got %h want %h", k, out_pc, 32'(4 * k)); end
      tick();
    end
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1 && out_pc === 32'd20) begin found = 1'b1; break; end
      tick();
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL redir_reach20 got %h want 00000014", out_pc); end
    redirect = 1'b1; redirect_pc = 32'h0000_000E;
    tick();
    redirect = 1'b0;
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_n1 got %h want 0", out_valid); end
    if (rom_addr !== 32'd12) begin n_fail++; $display("FAIL redir_rom_addr got %h want 0000000c", rom_addr); end
    tick();
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid_n2 got %h want 1", out_valid); end
    if (out_pc !== 32'd12) begin n_fail++; $display("FAIL redir_pc got %h want 0000000c", out_pc); end
    if (out_ins !== 32'h002181b3) begin n_fail++; $display("FAIL redir_ins got %h want 002181b3", out_ins); end
  endtask

  task automatic test_redirect_full();
    logic [31:0] tgt;
    out_ready = 1'b0;
    do_reset();
    tick(); tick();
    n_checks += 2;
    if (rom_addr !== 32'h8) begin n_fail++; $display("FAIL rfull_fill_addr got %h want 8", rom_addr); end
    if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rfull_fill_pc got %h want 0", out_pc); end
    redirect_pc = 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
    tgt = {redirect_pc[31:2], 2'b00};
    redirect = 1'b1; out_ready = 1'b1;
    tick();
    redirect = 1'b0;
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rfull_valid_n1 got %h want 0", out_valid); end
    if (rom_addr !== tgt) begin n_fail++; $display("FAIL rfull_rom_addr got %h want %h", rom_addr, tgt); end
    tick();
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rfull_valid_n2 got %h want 1", out_valid); end
    if (out_pc !== tgt) begin n_fail++; $display("FAIL rfull_pc got %h want %h", out_pc, tgt); end
    if (out_ins !== rom_word(tgt)) begin n_fail++; $display("FAIL rfull_ins got %h want %h", out_ins, rom_word(tgt)); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    do_reset();
    tick(); tick();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    rst = 1'b0; redirect = 1'b0;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %h want 0", out_valid); end
    if (out_ins !== 32'h13) begin n_fail++; $display("FAIL rmid_ins got %h want 00000013", out_ins); end
    if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rmid_pc got %h want 0", out_pc); end
    if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_rom_addr got %h want 0", rom_addr); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_ins [3];
    exp_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_ins = '{32'h08302023, 32'h0000006f, 32'h04002083};
    rst_w = 1'b0;
    n_checks += 2;
    if (rom_addr_w !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_reset_addr got %h want fffffff8", rom_addr_w); end
    if (out_valid_w !== 1'b0) begin n_fail++; $display("FAIL wrap_reset_valid got %h want 0", out_valid_w); end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks += 3;
      if (out_valid_w !== 1'b1) begin n_fail++; $display("FAIL wrap_valid[%0d] got %h want 1", k, out_valid_w); end
      if (out_pc_w !== exp_pc[k]) begin n_fail++; $display("FAIL wrap_pc[%0d] got %h want %h", k, out_pc_w, exp_pc[k]); end
      if (out_ins_w !== exp_ins[k]) begin n_fail++; $display("FAIL wrap_ins[%0d] got %h want %h", k, out_ins_w, exp_ins[k]); end
      tick();
    end
  endtask

  task automatic test_random();
    fetch_entry_t head;
    logic         exp_valid;
    logic [31:0]  exp_pc, exp_ins;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      exp_valid = (mq.size() != 0);
      head      = exp_valid ? mq[0] : '{pc: 32'h0, ins: 32'h13};
      exp_pc    = head.pc;
      exp_ins   = head.ins;
      n_checks += 4;
      if (out_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid@%0d got %h want %h", c, out_valid, exp_valid); end
      if (out_pc !== exp_pc) begin n_fail++; $display("FAIL rand_pc@%0d got %h want %h", c, out_pc, exp_pc); end
      if (out_ins !== exp_ins) begin n_fail++; $display("FAIL rand_ins@%0d got %h want %h", c, out_ins, exp_ins); end
      if (rom_addr !== mpc) begin n_fail++; $display("FAIL rand_rom_addr@%0d got %h want %h", c, rom_addr, mpc); end
      out_ready   = ($urandom_range(0, 99) < 60);
      redirect    = ($urandom_range(0, 99) < 10);
      redirect_pc = 32'($urandom_range(0, 255));
      rst         = ($urandom_range(0, 99) < 2);
      tick();
    end
    rst = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    rst_w = 1'b1; redirect_w = 1'b0; redirect_pc_w = '0; out_ready_w = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_full();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch front end for the single-issue RISC-V core. It owns the program counter and drives a word address to the combinational instruction ROM, which returns the instruction in the same cycle. Each fetched {pc, instruction} pair goes into a small queue and is handed to decode over a valid/ready handshake. Decode or execute can redirect the fetch on a taken branch or jump, which flushes everything in flight.

## Interface
- RESET_PC, default 32'h0000_0000: PC value loaded on reset.
- DEPTH, default 2: fetch queue entries; must be a power of two, minimum 2.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  32  byte address to the ROM. It is always word aligned (bits [1:0] = 0).
- rom_ins  in  32  ROM data for rom_addr, valid in the same cycle.
- redirect  in  1  flush request for a taken branch, jal or jalr.
- redirect_pc  in  32  new fetch target. Bits [1:0] are ignored.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_ins  out  32  instruction at the queue head.
- out_pc  out  32  byte address of out_ins.

## Operation
- State:
  - pc register, 32 bits.
  - Queue of DEPTH entries, each {pc, ins}.
  - Read pointer and write pointer, each log2(DEPTH) bits.
  - count, log2(DEPTH)+1 bits.
- rom_addr = {pc[31:2], 2'b00}. It is driven from the register, never from redirect_pc combinationally.
- pop = out_valid && out_ready.
- push = !redirect && (count < DEPTH || pop).
  - A full queue with a pop in the same cycle still pushes.
- On push:
  - Entry gets {pc, rom_ins}.
  - pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- No push means pc holds.
- Redirect has priority over push and pop:
  - count <= 0 and both pointers <= 0.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - A pop asserted in the redirect cycle counts as consumed by decode, and the queue is still cleared.
- out_valid = (count != 0). out_ins and out_pc come from the read-pointer entry.
- When out_valid = 0, out_ins = 32'h0000_0013 (nop) and out_pc = 0. The outputs are never X.
- The block does not decode instructions. X from an unmapped ROM address passes through unchanged in out_ins.

## Timing
- Reset values:
  - pc = RESET_PC, so rom_addr = RESET_PC.
  - count = 0, out_valid = 0, out_ins = 32'h0000_0013, out_pc = 0.
- rst asserted mid-operation discards queue contents and any redirect presented in the same cycle.
- Latency after reset release:
  - Cycle 0 pushes RESET_PC.
  - out_valid = 1 in cycle 1 with out_pc = RESET_PC.
- Redirect latency:
  - Redirect in cycle N gives rom_addr = target in cycle N+1 and out_valid = 0 in cycle N+1.
  - The target instruction is presented in cycle N+2.
- With out_ready held high, one instruction per cycle is sustained and the queue never exceeds 1 entry.
- With out_ready low, the queue fills to DEPTH and then pc stalls. rom_addr stays at the next unfetched address.
- out_valid, once high, stays high with stable out_ins and out_pc until popped or redirected.
- Throughput is 1 instruction per clock. There is no combinational path from out_ready or redirect to rom_addr.

## Structure
- Shared package core_pkg holds:
  - INS_NOP = 32'h0000_0013.
  - XLEN = 32.
  - The fetch_entry_t typedef {pc[31:0], ins[31:0]}, also used by decode.
- Sub-module fetch_queue:
  - Generic DEPTH-entry synchronous FIFO with push, pop, flush, count, full and empty.
  - inst_fetch instantiates fetch_queue and keeps only the pc and push logic itself.

## Test plan
- Reset with RESET_PC = 0, out_ready = 1, ROM holding the 7-word square program.
  - Required: out_pc 0, 4, 8 … 24 on consecutive cycles from cycle 1.
  - Required: out_ins 04002083, 00008133, 000001b3 … 08302023.
- Backpressure: out_ready = 0 for 5 cycles after cycle 1.
  - Required: out_valid stays 1 with out_pc = 0.
  - Required: rom_addr freezes at 8 once 2 entries are held.
  - Releasing out_ready gives out_pc 0, 4, 8 with no gap and no duplicate.
- Redirect to loop start: redirect = 1 with redirect_pc = 32'h0000_000E while out_pc = 20.
  - Required: next cycle out_valid = 0 and rom_addr = 12.
  - Required: following cycle out_pc = 12 with out_ins = 002181b3.
- Redirect coincident with a full queue and pop = 1.
  - Required: queue empties, there is no push in that cycle, and the target appears 2 cycles later.
- PC wrap: RESET_PC = 32'hFFFF_FFF8 with out_ready = 1.
  - Required: out_pc FFFF_FFF8, FFFF_FFFC, then 0000_0000.
- Reset mid-stream: rst asserted while count = 2 and redirect = 1.
  - Required next cycle: out_valid = 0, out_ins = 00000013 and rom_addr = RESET_PC. The redirect target is ignored.
